// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART TX frame timer.
//   - phase encoding (PH_*), the FSM state type built on it
//   - data-bit count codes (DB_*) and the code-to-count mapping
//   - DEFAULT_DIV, the baud divisor used out of reset
package uart_pkg;

   // Phase encoding presented to the serialiser.
   localparam logic [2:0] PH_IDLE   = 3'd0;
   localparam logic [2:0] PH_START  = 3'd1;
   localparam logic [2:0] PH_DATA   = 3'd2;
   localparam logic [2:0] PH_PARITY = 3'd3;
   localparam logic [2:0] PH_STOP   = 3'd4;

   // The state encoding equals the phase encoding, so the phase output
   // is the state register itself.
   typedef enum logic [2:0] {
      ST_IDLE   = PH_IDLE,
      ST_START  = PH_START,
      ST_DATA   = PH_DATA,
      ST_PARITY = PH_PARITY,
      ST_STOP   = PH_STOP
   } phase_e;

   // Data-bit count codes.
   localparam logic [1:0] DB_5 = 2'd0;
   localparam logic [1:0] DB_6 = 2'd1;
   localparam logic [1:0] DB_7 = 2'd2;
   localparam logic [1:0] DB_8 = 2'd3;

   // Divisor loaded out of reset.
   localparam int DEFAULT_DIV = 10416;

   // Maps a data-bit code (0..3) to a data-bit count (5..8).
   function automatic logic [3:0] data_bits_count(input logic [1:0] code);
      return 4'd5 + {2'b00, code};
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: free-running 0..div counter that sets the bit period.
//   clk   - system clock
//   reset - asynchronous active-low reset
//   run   - count while high; counter is held at 0 while low
//   div   - terminal count (period = div + 1 clocks)
//   tick  - high while running and the count is 0 (first clock of a bit)
//   last  - high while running and the count equals div (last clock of a bit)
module uart_baud_counter #(
   parameter int DIV_W = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   output logic             tick,
   output logic             last
);

   logic [DIV_W-1:0] cnt_r;

   // Baud counter: wraps at div, parked at zero when not running.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r <= {DIV_W{1'b0}};
      end else if (!run) begin
         cnt_r <= {DIV_W{1'b0}};
      end else if (cnt_r == div) begin
         cnt_r <= {DIV_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
   end

   // With div == 0 both strobes are high on every running clock.
   assign tick = run && (cnt_r == {DIV_W{1'b0}});
   assign last = run && (cnt_r == div);

endmodule

// File: rtl/uart_tx_frame_timer.sv
// uart_tx_frame_timer: frame sequencer between the TX FIFO and the serialiser.
// Generates per-bit ticks, the current phase and data-bit index, a FIFO pop
// at the start of each frame and a done strobe at the end of each frame.
// Frame format and divisor are latched when a frame starts.
//   clk, reset        - system clock, asynchronous active-low reset
//   iTX_en            - level request; frames repeat back-to-back while high
//   iDIV              - baud divisor (bit period = iDIV + 1 clocks)
//   iDATA_BITS        - data bit code, 0..3 -> 5..8 bits
//   iPARITY_EN        - insert one parity bit after the data bits
//   iSTOP2            - two stop bits instead of one
//   oBIT_tick         - first clock of every bit period
//   oPHASE            - 0 idle, 1 start, 2 data, 3 parity, 4 stop
//   oBIT_IDX          - data bit index during DATA, else 0
//   oFIFO_pop         - first clock of every START bit
//   oBUSY             - phase is not IDLE
//   oFRAME_done       - last clock of the final stop bit
module uart_tx_frame_timer #(
   parameter int DIV_W       = 14,
   parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             iTX_en,
   input  logic [DIV_W-1:0] iDIV,
   input  logic [1:0]       iDATA_BITS,
   input  logic             iPARITY_EN,
   input  logic             iSTOP2,
   output logic             oBIT_tick,
   output logic [2:0]       oPHASE,
   output logic [2:0]       oBIT_IDX,
   output logic             oFIFO_pop,
   output logic             oBUSY,
   output logic             oFRAME_done
);

   import uart_pkg::*;

   localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

   phase_e           state_r, state_n;
   logic [2:0]       idx_r, idx_n;
   logic             second_r, second_n;   // second stop bit in progress
   logic [DIV_W-1:0] div_r;
   logic [1:0]       bits_r;
   logic             par_r;
   logic             stop2_r;
   logic             latch_s;
   logic             run_s, tick_s, last_s;
   logic [2:0]       last_idx_s;
   logic             final_stop_s;

   assign run_s        = (state_r != ST_IDLE);
   assign last_idx_s   = 3'(data_bits_count(bits_r) - 4'd1);
   assign final_stop_s = !stop2_r || second_r;

   uart_baud_counter #(
      .DIV_W (DIV_W)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .run   (run_s),
      .div   (div_r),
      .tick  (tick_s),
      .last  (last_s)
   );

   // FSM state, data index and stop-bit counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_IDLE;
         idx_r    <= 3'd0;
         second_r <= 1'b0;
      end else begin
         state_r  <= state_n;
         idx_r    <= idx_n;
         second_r <= second_n;
      end
   end

   // Frame configuration, captured only on entry to START.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_r   <= RESET_DIV;
         bits_r  <= DB_8;
         par_r   <= 1'b0;
         stop2_r <= 1'b0;
      end else if (latch_s) begin
         div_r   <= iDIV;
         bits_r  <= iDATA_BITS;
         par_r   <= iPARITY_EN;
         stop2_r <= iSTOP2;
      end
   end

   // Next-state logic; every transition happens on the last clock of a bit.
   always_comb begin
      state_n  = state_r;
      idx_n    = idx_r;
      second_n = second_r;
      latch_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (iTX_en) begin
               state_n = ST_START;
               latch_s = 1'b1;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_START: begin
            if (last_s) begin
               state_n = ST_DATA;
               idx_n   = 3'd0;
            end else begin
               state_n = ST_START;
            end
         end
         ST_DATA: begin
            if (last_s) begin
               if (idx_r == last_idx_s) begin
                  idx_n   = 3'd0;
                  state_n = par_r ? ST_PARITY : ST_STOP;
               end else begin
                  idx_n = idx_r + 3'd1;
               end
            end else begin
               state_n = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (last_s) begin
               state_n  = ST_STOP;
               second_n = 1'b0;
            end else begin
               state_n = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (last_s) begin
               if (!final_stop_s) begin
                  second_n = 1'b1;
               end else begin
                  // Frame ends; a held request chains straight into START.
                  second_n = 1'b0;
                  if (iTX_en) begin
                     state_n = ST_START;
                     latch_s = 1'b1;
                  end else begin
                     state_n = ST_IDLE;
                  end
               end
            end else begin
               state_n = ST_STOP;
            end
         end
         default: begin
            state_n  = ST_IDLE;
            idx_n    = 3'd0;
            second_n = 1'b0;
         end
      endcase
   end

   // Outputs decode registered state only; idx_r is zero outside DATA.
   assign oBIT_tick   = tick_s;
   assign oPHASE      = state_r;
   assign oBIT_IDX    = idx_r;
   assign oFIFO_pop   = (state_r == ST_START) && tick_s;
   assign oBUSY       = run_s;
   assign oFRAME_done = (state_r == ST_STOP) && last_s && final_stop_s;

endmodule

// File: tb/tb_uart_tx_frame_timer.sv
// Directed testbench for uart_tx_frame_timer. Each test starts right after a
// rising edge ("cycle 0"); cyc() advances one clock and samples #1 later.
module tb_uart_tx_frame_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        iTX_en;
   logic [13:0] iDIV;
   logic [1:0]  iDATA_BITS;
   logic        iPARITY_EN;
   logic        iSTOP2;
   logic        oBIT_tick;
   logic [2:0]  oPHASE;
   logic [2:0]  oBIT_IDX;
   logic        oFIFO_pop;
   logic        oBUSY;
   logic        oFRAME_done;

   int checks = 0;
   int errors = 0;
   int cycle;
   int tick_q[$];
   int tph_q[$];
   int tidx_q[$];
   int pop_q[$];
   int done_q[$];
   logic [2:0] ph_log [0:255];
   logic       busy_log [0:255];

   always #5 clk = ~clk;

   uart_tx_frame_timer dut (
      .clk         (clk),
      .reset       (reset),
      .iTX_en      (iTX_en),
      .iDIV        (iDIV),
      .iDATA_BITS  (iDATA_BITS),
      .iPARITY_EN  (iPARITY_EN),
      .iSTOP2      (iSTOP2),
      .oBIT_tick   (oBIT_tick),
      .oPHASE      (oPHASE),
      .oBIT_IDX    (oBIT_IDX),
      .oFIFO_pop   (oFIFO_pop),
      .oBUSY       (oBUSY),
      .oFRAME_done (oFRAME_done)
   );

   task automatic clear_logs();
      tick_q.delete(); tph_q.delete(); tidx_q.delete();
      pop_q.delete(); done_q.delete();
      for (int i = 0; i < 256; i++) begin
         ph_log[i]   = 3'd0;
         busy_log[i] = 1'b0;
      end
      cycle = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      cycle++;
      if (cycle < 256) begin
         ph_log[cycle]   = oPHASE;
         busy_log[cycle] = oBUSY;
      end
      if (oBIT_tick) begin
         tick_q.push_back(cycle);
         tph_q.push_back(int'(oPHASE));
         tidx_q.push_back(int'(oBIT_IDX));
      end
      if (oFIFO_pop)   pop_q.push_back(cycle);
      if (oFRAME_done) done_q.push_back(cycle);
   endtask

   // Number of entries q[first+k], k<n, differing from start+k*step.
   function automatic int prog_bad(input int q[$], input int first,
                                   input int start, input int step, input int n);
      int bad = 0;
      for (int k = 0; k < n; k++) begin
         if (first + k >= q.size()) bad++;
         else if (q[first + k] != start + k * step) bad++;
      end
      return bad;
   endfunction

   // Number of cycles in [lo,hi] where busy does not match (phase != IDLE) or busy != want.
   function automatic int busy_bad(input int lo, input int hi, input bit want);
      int bad = 0;
      for (int c = lo; c <= hi; c++) begin
         if (busy_log[c] !== want || busy_log[c] !== (ph_log[c] != 3'd0)) bad++;
      end
      return bad;
   endfunction

   task automatic test_reset();
      reset = 1'b0; iTX_en = 1'b0; iDIV = 14'd3; iDATA_BITS = 2'd3;
      iPARITY_EN = 1'b0; iSTOP2 = 1'b0;
      clear_logs();
      repeat (3) cyc();
      checks++;
      if ({oBIT_tick, oPHASE, oBIT_IDX, oFIFO_pop, oBUSY, oFRAME_done} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0", {oBIT_tick, oPHASE, oBIT_IDX, oFIFO_pop, oBUSY, oFRAME_done});
      end
      reset = 1'b1;
      repeat (3) cyc();
      checks++;
      if (oBUSY !== 1'b0 || oPHASE !== 3'd0) begin
         errors++;
         $display("FAIL idle_after_release: busy %b phase %0d expected 0 0", oBUSY, oPHASE);
      end
   endtask

   task automatic test_8n1();
      int bad;
      int eph, eidx;
      iDIV = 14'd3; iDATA_BITS = 2'd3; iPARITY_EN = 1'b0; iSTOP2 = 1'b0;
      clear_logs();
      iTX_en = 1'b1;
      cyc();
      iTX_en = 1'b0;
      repeat (44) cyc();
      checks++;
      if (pop_q.size() != 1 || prog_bad(pop_q, 0, 1, 1, 1) != 0) begin
         errors++;
         $display("FAIL 8n1_pop: got %0d pops first at %0d expected 1 pop at 1", pop_q.size(), pop_q.size() > 0 ? pop_q[0] : -1);
      end
      checks++;
      if (tick_q.size() != 10) begin
         errors++;
         $display("FAIL 8n1_tick_count: got %0d expected 10", tick_q.size());
      end
      bad = prog_bad(tick_q, 0, 1, 4, 10);
      for (int k = 0; k < tick_q.size() && k < 10; k++) begin
         eph  = (k == 0) ? 1 : ((k <= 8) ? 2 : 4);
         eidx = (k >= 1 && k <= 8) ? k - 1 : 0;
         if (tph_q[k] != eph || tidx_q[k] != eidx) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL 8n1_bit_sequence: got %0d wrong ticks expected 0", bad);
      end
      checks++;
      if (done_q.size() != 1 || prog_bad(done_q, 0, 40, 1, 1) != 0) begin
         errors++;
         $display("FAIL 8n1_done: got %0d dones first at %0d expected 1 at 40", done_q.size(), done_q.size() > 0 ? done_q[0] : -1);
      end
      checks++;
      if (busy_bad(1, 40, 1'b1) != 0 || busy_bad(41, 44, 1'b0) != 0) begin
         errors++;
         $display("FAIL 8n1_busy_window: got phase %0d at 41 expected busy 1..40 then idle", ph_log[41]);
      end
   endtask

   task automatic test_5e2();
      int exp_ph [0:8]  = '{1, 2, 2, 2, 2, 2, 3, 4, 4};
      int exp_idx [0:8] = '{0, 0, 1, 2, 3, 4, 0, 0, 0};
      int bad;
      iDIV = 14'd1; iDATA_BITS = 2'd0; iPARITY_EN = 1'b1; iSTOP2 = 1'b1;
      clear_logs();
      iTX_en = 1'b1;
      cyc();
      iTX_en = 1'b0;
      repeat (22) cyc();
      checks++;
      if (tick_q.size() != 9) begin
         errors++;
         $display("FAIL 5e2_tick_count: got %0d expected 9", tick_q.size());
      end
      bad = prog_bad(tick_q, 0, 1, 2, 9);
      for (int k = 0; k < tick_q.size() && k < 9; k++) begin
         if (tph_q[k] != exp_ph[k] || tidx_q[k] != exp_idx[k]) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL 5e2_bit_sequence: got %0d wrong ticks expected 0", bad);
      end
      checks++;
      if (done_q.size() != 1 || prog_bad(done_q, 0, 18, 1, 1) != 0) begin
         errors++;
         $display("FAIL 5e2_done: got %0d dones first at %0d expected 1 at 18", done_q.size(), done_q.size() > 0 ? done_q[0] : -1);
      end
      checks++;
      if (busy_bad(1, 18, 1'b1) != 0 || busy_bad(19, 22, 1'b0) != 0) begin
         errors++;
         $display("FAIL 5e2_busy_window: got phase %0d at 19 expected 18 busy clocks", ph_log[19]);
      end
   endtask

   task automatic test_back_to_back();
      iDIV = 14'd2; iDATA_BITS = 2'd3; iPARITY_EN = 1'b0; iSTOP2 = 1'b0;
      clear_logs();
      iTX_en = 1'b1;
      repeat (65) cyc();
      iTX_en = 1'b0;
      repeat (30) cyc();
      checks++;
      if (pop_q.size() != 3 || prog_bad(pop_q, 0, 1, 30, 3) != 0) begin
         errors++;
         $display("FAIL b2b_pops: got %0d pops expected 3 at 1,31,61", pop_q.size());
      end
      checks++;
      if (done_q.size() != 3 || prog_bad(done_q, 0, 30, 30, 3) != 0) begin
         errors++;
         $display("FAIL b2b_dones: got %0d dones expected 3 at 30,60,90", done_q.size());
      end
      checks++;
      if (tick_q.size() != 30 || prog_bad(tick_q, 0, 1, 3, 30) != 0) begin
         errors++;
         $display("FAIL b2b_ticks: got %0d ticks expected 30 every 3 clocks", tick_q.size());
      end
      checks++;
      if (busy_bad(1, 90, 1'b1) != 0 || busy_bad(91, 95, 1'b0) != 0) begin
         errors++;
         $display("FAIL b2b_busy: got %0d bad clocks in 1..90 expected 0", busy_bad(1, 90, 1'b1));
      end
   endtask

   task automatic test_div_change();
      iDIV = 14'd3; iDATA_BITS = 2'd3; iPARITY_EN = 1'b0; iSTOP2 = 1'b0;
      clear_logs();
      iTX_en = 1'b1;
      repeat (10) cyc();
      iDIV = 14'd7;
      repeat (35) cyc();
      iTX_en = 1'b0;
      iDIV = 14'd1;
      repeat (80) cyc();
      checks++;
      if (tick_q.size() != 20 || prog_bad(tick_q, 0, 1, 4, 10) != 0) begin
         errors++;
         $display("FAIL divchg_first_frame: got %0d ticks expected 20 with first 10 every 4", tick_q.size());
      end
      checks++;
      if (prog_bad(tick_q, 10, 41, 8, 10) != 0) begin
         errors++;
         $display("FAIL divchg_second_frame: got %0d off-grid ticks expected 0", prog_bad(tick_q, 10, 41, 8, 10));
      end
      checks++;
      if (pop_q.size() != 2 || prog_bad(pop_q, 0, 1, 40, 2) != 0 ||
          done_q.size() != 2 || prog_bad(done_q, 0, 40, 80, 2) != 0) begin
         errors++;
         $display("FAIL divchg_pop_done: got %0d pops %0d dones expected pops 1,41 dones 40,120", pop_q.size(), done_q.size());
      end
      checks++;
      if (busy_bad(1, 120, 1'b1) != 0 || busy_bad(121, 125, 1'b0) != 0) begin
         errors++;
         $display("FAIL divchg_busy: got phase %0d at 121 expected busy 1..120 then idle", ph_log[121]);
      end
   endtask

   task automatic test_drop_mid_frame();
      iDIV = 14'd3; iDATA_BITS = 2'd3; iPARITY_EN = 1'b0; iSTOP2 = 1'b0;
      clear_logs();
      iTX_en = 1'b1;
      repeat (14) cyc();
      checks++;
      if (oPHASE !== 3'd2 || oBIT_IDX !== 3'd2) begin
         errors++;
         $display("FAIL drop_position: got phase %0d idx %0d expected 2 2", oPHASE, oBIT_IDX);
      end
      iTX_en = 1'b0;
      repeat (36) cyc();
      checks++;
      if (pop_q.size() != 1 || done_q.size() != 1 || prog_bad(done_q, 0, 40, 1, 1) != 0) begin
         errors++;
         $display("FAIL drop_completion: got %0d pops %0d dones expected 1 pop and done at 40", pop_q.size(), done_q.size());
      end
      checks++;
      if (busy_bad(1, 40, 1'b1) != 0 || busy_bad(41, 50, 1'b0) != 0) begin
         errors++;
         $display("FAIL drop_idle: got phase %0d at 41 expected busy 1..40 then idle", ph_log[41]);
      end
   endtask

   task automatic test_reset_mid_frame();
      iDIV = 14'd3; iDATA_BITS = 2'd2; iPARITY_EN = 1'b1; iSTOP2 = 1'b0;
      clear_logs();
      iTX_en = 1'b1;
      cyc();
      iTX_en = 1'b0;
      repeat (33) cyc();
      checks++;
      if (oPHASE !== 3'd3) begin
         errors++;
         $display("FAIL rst_mid_in_parity: got phase %0d expected 3", oPHASE);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({oBIT_tick, oPHASE, oBIT_IDX, oFIFO_pop, oBUSY, oFRAME_done} !== 10'd0) begin
         errors++;
         $display("FAIL rst_mid_async: got %b expected 0", {oBIT_tick, oPHASE, oBIT_IDX, oFIFO_pop, oBUSY, oFRAME_done});
      end
      repeat (5) cyc();
      reset = 1'b1;
      repeat (2) cyc();
      checks++;
      if (done_q.size() != 0 || oBUSY !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_no_done: got %0d dones busy %b expected 0 0", done_q.size(), oBUSY);
      end
      // Fresh request with a 1-clock bit period: tick high for the whole frame.
      iDIV = 14'd0; iDATA_BITS = 2'd3; iPARITY_EN = 1'b0; iSTOP2 = 1'b0;
      clear_logs();
      iTX_en = 1'b1;
      cyc();
      iTX_en = 1'b0;
      repeat (12) cyc();
      checks++;
      if (tick_q.size() != 10 || prog_bad(tick_q, 0, 1, 1, 10) != 0 ||
          pop_q.size() != 1 || prog_bad(pop_q, 0, 1, 1, 1) != 0) begin
         errors++;
         $display("FAIL div0_ticks: got %0d ticks %0d pops expected 10 ticks at 1..10 and 1 pop at 1", tick_q.size(), pop_q.size());
      end
      checks++;
      if (done_q.size() != 1 || prog_bad(done_q, 0, 10, 1, 1) != 0 || busy_bad(11, 13, 1'b0) != 0) begin
         errors++;
         $display("FAIL div0_done: got %0d dones phase %0d at 11 expected done at 10 then idle", done_q.size(), ph_log[11]);
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_5e2();
      test_back_to_back();
      test_div_change();
      test_drop_mid_frame();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame_timer.md
Name: uart_tx_frame_timer

Overview:
Parametrised successor to the fixed-rate TX baud generator. It adds a runtime-programmable divisor and runtime frame format: 5-8 data bits, optional parity, 1 or 2 stop bits. A frame-sequencing FSM drives per-bit ticks, bit index and phase, plus a once-per-frame FIFO pop. It sits between the TX FIFO and the TX shift/serialiser logic; the serialiser consumes oBIT_tick, oPHASE and oBIT_IDX.

Parameters:
DIV_W, 14, width of the baud divisor and the internal baud counter.
DEFAULT_DIV, 10416, divisor value loaded into the config register at reset (period = DIV+1 clocks).

Ports:
clk  input  1  system clock; sole clock domain.
reset  input  1  asynchronous, active-low reset.
iTX_en  input  1  level request: start a frame, and keep starting frames back-to-back while high.
iDIV  input  DIV_W  baud divisor; bit period = iDIV+1 clocks; sampled at frame start only.
iDATA_BITS  input  2  data-bit count code: 0=5, 1=6, 2=7, 3=8; sampled at frame start.
iPARITY_EN  input  1  1 = insert one parity bit after data; sampled at frame start.
iSTOP2  input  1  1 = two stop bits, 0 = one; sampled at frame start.
oBIT_tick  output  1  one-cycle pulse on the first clock of every bit period.
oPHASE  output  3  0=IDLE, 1=START, 2=DATA, 3=PARITY, 4=STOP.
oBIT_IDX  output  3  data bit index (LSB first) while in DATA; 0 otherwise.
oFIFO_pop  output  1  one-cycle pulse on the first clock of each START bit.
oBUSY  output  1  high whenever oPHASE != IDLE.
oFRAME_done  output  1  one-cycle pulse on the last clock of the final stop bit.

Behaviour:
- Reset (async, reset=0): FSM to IDLE; baud counter 0; config register = {DEFAULT_DIV, 8 data bits, no parity, 1 stop}. All outputs are 0.
- All outputs are registered, or decoded purely from registered state; no combinational path from inputs to outputs.
- Frame start, IDLE with iTX_en=1 at a rising edge:
  - next cycle is START with counter=0;
  - iDIV, iDATA_BITS, iPARITY_EN and iSTOP2 are latched on that same edge.
- Input changes after the latch edge have no effect until the next frame start.
- Bit timing: counter runs 0..div_q and wraps to 0 while not IDLE; it is held at 0 in IDLE.
  - oBIT_tick = (counter==0) && !IDLE.
  - The phase/index advance on the edge where counter==div_q.
  - div_q=0 gives a 1-clock bit period: oBIT_tick is continuously high while busy.
- FSM transitions (taken at bit end):
  - START -> DATA (idx 0).
  - DATA: idx increments until N-1, then -> PARITY if parity enabled, else -> STOP.
  - PARITY -> STOP.
  - STOP: stays one bit (or two bits if iSTOP2 was latched), then ends the frame.
- Frame end:
  - iTX_en=1 at that edge: go directly to START (no idle gap), re-latch config, pulse oFIFO_pop again.
  - iTX_en=0: go to IDLE.
- iTX_en deasserted mid-frame: the frame completes normally; there is no abort. This differs from the predecessor, which cleared its counter.
- Frame length = (1 + N + P + S) * (div_q + 1) clocks.
  - oFIFO_pop coincides with the first oBIT_tick of the frame.
  - oFRAME_done is high on the cycle where phase=STOP, the final stop bit is active and counter==div_q.
- Counter width is DIV_W; div_q is at most 2^DIV_W-1, so there is no overflow.
- Reset asserted mid-frame: immediate return to reset state; no oFRAME_done is issued.

Decomposition:
- Package uart_pkg holds:
  - phase encoding constants: PH_IDLE, PH_START, PH_DATA, PH_PARITY, PH_STOP;
  - data-bit code constants and the code-to-count mapping function;
  - DEFAULT_DIV.
- One natural sub-module, uart_baud_counter, with ports clk, reset, run, div, tick, last:
  - a free-running 0..div counter, held at 0 when run=0;
  - tick at count 0; last at count==div.
- The FSM, config latch and output decode live in uart_tx_frame_timer.

Test Plan:
- 8N1, iDIV=3, single-cycle iTX_en pulse at cycle 0:
  - oFIFO_pop and oBIT_tick at cycle 1;
  - ticks every 4 clocks, 10 in total;
  - oFRAME_done at cycle 40, IDLE at cycle 41.
- 5E2 (code 0, parity, iSTOP2=1), iDIV=1:
  - phases START, DATA idx 0..4, PARITY, STOP, STOP;
  - 9 bits = 18 clocks; oFRAME_done exactly once.
- iTX_en held high, 8N1, iDIV=2:
  - back-to-back frames with no IDLE cycle;
  - oFIFO_pop every 30 clocks;
  - oBUSY stays high continuously.
- iDIV changed 3->7 mid-frame:
  - current frame keeps a 4-clock period;
  - the next frame uses 8;
  - config latches only at START entry.
- iTX_en dropped during DATA bit 2: the frame completes, then IDLE, with no second oFIFO_pop.
- reset pulsed low during PARITY:
  - all outputs 0 asynchronously, with no oFRAME_done;
  - after release the config equals DEFAULT_DIV/8N1 and the next request runs a frame.
